// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared types and constants for the hex display controller
//
// Purpose : FSM state enum, active-low seven-segment patterns and the
//           counter-width helper used by hex_display_ctrl and seg7_decode.
// Ports   : none (package).
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Bits needed to hold a bit counter that is loaded with w and counts to 0.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD nibble to active-low seven-segment decoder
//
// Purpose : maps a BCD digit 0..9 to its segment pattern; codes above 9 blank.
// Ports   : bcd (in, 4)  - BCD digit
//           seg (out, 7) - active-low segment pattern
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - sequential binary-to-BCD seven-segment display controller
//
// Purpose : on load, converts an unsigned value to BCD by double-dabble
//           (one bit per cycle) and latches the decoded digits onto hex_out.
//           Macro HEX_DISPLAY_CTRL_LZB_EN enables leading-zero blanking.
// Ports   : CLOCK_50 (in, 1)          - clock, rising edge
//           reset    (in, 1)          - synchronous, active-high
//           value    (in, WIDTH)      - unsigned binary value
//           load     (in, 1)          - conversion request, sampled in IDLE
//           busy     (out, 1)         - conversion in progress
//           done     (out, 1)         - high for the cycle the displays update
//           hex_out  (out, 7*DIGITS)  - active-low segments, digit 0 in [6:0]
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = cnt_width(WIDTH);

    // DIGITS decimal digits must hold the largest WIDTH-bit value, otherwise
    // the 4-bit add-3 step could overflow a nibble.
    function automatic bit digits_fit(input int w, input int d);
        longint p10;
        p10 = 1;
        for (int i = 0; i < d; i++) p10 = p10 * 10;
        return p10 > (longint'(1) << w);
    endfunction

    if (!digits_fit(WIDTH, DIGITS)) begin : g_digits_check
        $error("hex_display_ctrl: DIGITS too small for WIDTH");
    end

    state_e               state_q, state_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7*DIGITS-1:0]  hex_q, hex_d;

    logic [BW-1:0]        bcd_adj;
    logic [7*DIGITS-1:0]  seg_raw;
    logic [7*DIGITS-1:0]  seg_disp;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .bcd (bcd_q[4*g +: 4]),
            .seg (seg_raw[7*g +: 7])
        );
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef HEX_DISPLAY_CTRL_LZB_EN
    logic leading;
`endif

    // Digit 0 is never blanked so that zero still shows a single "0".
    always_comb begin
        seg_disp = seg_raw;
`ifdef HEX_DISPLAY_CTRL_LZB_EN
        leading = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (leading && (bcd_q[4*i +: 4] == 4'd0)) begin
                seg_disp[7*i +: 7] = SEG_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = value;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d            = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                hex_d   = seg_disp;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            hex_q   <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == LATCH);
    assign hex_out = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [7:0]  value;
    logic        load;
    logic        busy;
    logic        done;
    logic [20:0] hex_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [20:0] ALL_BLANK = {7'h7f, 7'h7f, 7'h7f};

    logic [20:0] disp_exp;

    hex_display_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .hex_out  (hex_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Load v at edge k; done must be seen after edge k+8, display after k+9.
    task automatic convert(input logic [7:0] v, input logic [20:0] exp_hex, input string tag);
        int lat;
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        value = ~v;
        check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 8);
        check_eq({tag, "_hold"}, 32'(hex_out), 32'(disp_exp));
        check_eq({tag, "_busy_latch"}, 32'(busy), 32'd1);
        step();
        check_eq({tag, "_hex"}, 32'(hex_out), 32'(exp_hex));
        check_eq({tag, "_done_end"}, 32'(done), 32'd0);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
        disp_exp = exp_hex;
    endtask

    initial begin
        int dones;
        int gap;
        reset = 1'b1;
        load  = 1'b0;
        value = 8'd0;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        check_eq("reset_hex", 32'(hex_out), 32'(ALL_BLANK));
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        disp_exp = ALL_BLANK;

        convert(8'd255, {7'h24, 7'h12, 7'h12}, "v255");
`ifdef HEX_DISPLAY_CTRL_LZB_EN
        convert(8'd7,   {7'h7f, 7'h7f, 7'h78}, "v7");
        convert(8'd0,   {7'h7f, 7'h7f, 7'h40}, "v0");
`else
        convert(8'd7,   {7'h40, 7'h40, 7'h78}, "v7");
        convert(8'd0,   {7'h40, 7'h40, 7'h40}, "v0");
`endif
        convert(8'd100, {7'h79, 7'h40, 7'h40}, "v100");

        // Second load during conversion must be ignored.
        value = 8'd42;
        load  = 1'b1;
        step();
        load  = 1'b0;
        dones = 0;
        for (int j = 1; j <= 12; j++) begin
            if (j == 3) begin
                value = 8'd99;
                load  = 1'b1;
            end
            step();
            load = 1'b0;
            if (done === 1'b1) dones++;
            if (j == 9) begin
                check_eq("ign_busy_k10", 32'(busy), 32'd0);
`ifdef HEX_DISPLAY_CTRL_LZB_EN
                check_eq("ign_hex", 32'(hex_out), 32'({7'h7f, 7'h19, 7'h24}));
`else
                check_eq("ign_hex", 32'(hex_out), 32'({7'h40, 7'h19, 7'h24}));
`endif
            end
        end
        check_eq("ign_done_count", dones, 1);

        // Reset in the middle of a conversion.
        value = 8'd128;
        load  = 1'b1;
        step();
        load  = 1'b0;
        dones = 0;
        repeat (3) begin
            step();
            if (done === 1'b1) dones++;
        end
        reset = 1'b1;
        step();
        check_eq("abort_hex", 32'(hex_out), 32'(ALL_BLANK));
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (10) begin
            step();
            if (done === 1'b1) dones++;
        end
        check_eq("abort_no_done", dones, 0);
        disp_exp = ALL_BLANK;
        convert(8'd128, {7'h79, 7'h24, 7'h00}, "v128");

        // load held high: one conversion every WIDTH+2 cycles.
        value = 8'd255;
        load  = 1'b1;
        gap   = 0;
        while (done !== 1'b1 && gap < 30) begin
            step();
            gap++;
        end
        gap = 0;
        step();
        gap++;
        while (done !== 1'b1 && gap < 30) begin
            step();
            gap++;
        end
        check_eq("held_gap", gap, 10);
        load = 1'b0;
        step();
        check_eq("held_hex", 32'(hex_out), 32'({7'h24, 7'h12, 7'h12}));
        check_eq("held_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
